auth_controller: RTL and testbench
==================================

Name: auth_controller

Overview:
- Reader-side challenge/response authentication FSM for an NFC access-control chip.
- Loads a 128-bit pre-shared key (PSK) bytewise from EEPROM and obtains a 64-bit reader nonce (RN) from the RNG.
- Exchanges challenge and response with the card through the NFC command port, verifies the response with the external AES core, and reports success/failure and the card identity.

Parameters:
- KEY_BASE_ADDR, 7'd0: EEPROM address of PSK byte 0 (MSB).
- NFC_CHAL_ADDR, 6'h00: first NFC address for RN bytes (8 writes).
- NFC_RESP_ADDR, 6'h10: first NFC address of the card response (16 reads).
- NFC_ACK_ADDR, 6'h20: first NFC address for the reader proof (16 writes, optional feature).

Ports:
- clk in 1: clock. Reset rst_n, asynchronous, active-low; clock clk.
- rst_n in 1: async active-low reset.
- start_auth in 1: one-cycle start request; ignored while busy.
- key_load_req out 1: one-cycle EEPROM read request.
- key_addr out 7: EEPROM byte address.
- key_data in 8: EEPROM read data.
- key_data_valid in 1: key_data valid.
- auth_success out 1: sticky success flag.
- auth_failed out 1: sticky failure flag.
- auth_busy out 1: authentication in progress.
- card_id out 128: identity of the authenticated card.
- card_id_valid out 1: card_id valid.
- aes_start out 1: one-cycle AES start.
- aes_mode out 1: 1=encrypt, 0=decrypt.
- aes_key out 128: loaded PSK.
- aes_block_in out 128: AES input block.
- aes_block_out in 128: AES result.
- aes_done in 1: AES result valid.
- nonce_req out 1: one-cycle nonce request.
- nonce_valid in 1: nonce valid.
- nonce in 64: random nonce.
- nfc_cmd_valid out 1: NFC command request.
- nfc_cmd_ready in 1: NFC accepts the command.
- nfc_cmd_write out 1: 1=write, 0=read.
- nfc_cmd_addr out 6: NFC register address.
- nfc_cmd_wdata out 8: write data.
- nfc_cmd_rdata in 8: read data, valid with done.
- nfc_cmd_done in 1: command complete.
- timeout_start out 1: one-cycle pulse that arms the external timer.
- timeout_occurred in 1: timer expired.

Behaviour:
- Reset: every output 0, key/RN/response registers 0, state=IDLE.
- Internal register `state` is 5 bits. Encoding, in order 0..17: IDLE, KEY_REQ, KEY_WAIT, NONCE_REQ, NONCE_WAIT, TX_RN, TX_RN_WAIT, RX_RESP, RX_RESP_WAIT, DEC_START, DEC_WAIT, VERIFY, ENC_START, ENC_WAIT, TX_ACK, TX_ACK_WAIT, SUCCESS, FAIL.
- IDLE, SUCCESS or FAIL + start_auth:
  - clear auth_success, auth_failed, card_id_valid and the byte counter;
  - set auth_busy;
  - go to KEY_REQ.
- PSK load:
  - KEY_REQ pulses key_load_req for one cycle with key_addr=KEY_BASE_ADDR+i, then goes to KEY_WAIT.
  - On key_data_valid, key_data is stored to aes_key[127-8i -: 8] (byte 0 = MSB).
  - For i<15, return to KEY_REQ; otherwise go to NONCE_REQ.
- Nonce:
  - nonce_req is a one-cycle pulse.
  - nonce_valid is accepted in the request cycle or any later cycle; RN latches from nonce.
- NFC transaction:
  - Hold nfc_cmd_valid with stable addr, write and wdata until nfc_cmd_ready is sampled high.
  - Complete on the first cycle with nfc_cmd_done (the acceptance cycle counts); nfc_cmd_rdata is sampled that cycle.
  - nfc_cmd_valid is low the cycle after completion.
- TX_RN: write RN bytes MSB-first to NFC_CHAL_ADDR+0..7.
- RX_RESP: on entry, pulse timeout_start once; read 16 bytes from NFC_RESP_ADDR+0..15 into RESP, MSB-first.
- DEC:
  - Pulse aes_start with aes_mode=0 and aes_block_in=RESP.
  - Capture aes_block_out on aes_done, including the start cycle; the result is P.
- VERIFY:
  - P[127:64]==RN: card_id<=P, then continue (optional feature) or go to SUCCESS.
  - Otherwise go to FAIL.
- timeout_occurred in any state from TX_RN to TX_ACK_WAIT goes to FAIL.
- SUCCESS: auth_success=1, card_id_valid=1, auth_busy=0; the flags hold until the next start_auth.
- FAIL: auth_failed=1, auth_busy=0, card_id_valid=0.
- auth_success and auth_failed are never high together.
- Reset mid-operation: immediate abort to the reset values.

Optional Feature:
- MUTUAL_AUTH_EN defined:
  - After VERIFY, ENC encrypts {P[63:0], RN} (aes_mode=1).
  - TX_ACK then writes the 16 result bytes MSB-first to NFC_ACK_ADDR+0..15, then goes to SUCCESS.
- MUTUAL_AUTH_EN undefined: VERIFY goes directly to SUCCESS; the ENC/TX_ACK states are unreachable.

Test Plan:
- PSK 2b7e151628aed2a6abf7158809cf4f3c in EEPROM 0..15 (mock response one cycle after request), start_auth -> key_addr 0..15 in order, one request per byte, aes_key == PSK before nonce_req.
- Nonce fedcba9876543210, NFC ready=1, done=valid -> writes to addr 0..7 carry fe,dc,ba,98,76,54,32,10; timeout_start pulses once.
- XOR AES model (out=in^key), card returns {RN, 64'h0123456789abcdef}^PSK -> auth_success=1, card_id=fedcba98765432100123456789abcdef, card_id_valid=1, auth_busy=0.
- Card reads constant 8'hAA -> auth_failed=1, auth_success=0, card_id_valid=0.
- timeout_occurred=1 during RX_RESP_WAIT -> FAIL within 1 cycle; then start_auth -> flags clear and the flow restarts.
- rst_n low during KEY_WAIT -> all outputs 0, state=0; start_auth during busy -> ignored.

Source files
------------

// File: rtl/auth_controller.sv
// Reader-side challenge/response authentication FSM: PSK load, nonce, NFC exchange, AES verify.
// Define MUTUAL_AUTH_EN to send the encrypted reader proof back to the card after a good verify.
module auth_controller #(
  parameter logic [6:0] KEY_BASE_ADDR = 7'd0,
  parameter logic [5:0] NFC_CHAL_ADDR = 6'h00,
  parameter logic [5:0] NFC_RESP_ADDR = 6'h10,
  parameter logic [5:0] NFC_ACK_ADDR  = 6'h20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_auth,
  output logic         key_load_req,
  output logic [6:0]   key_addr,
  input  logic [7:0]   key_data,
  input  logic         key_data_valid,
  output logic         auth_success,
  output logic         auth_failed,
  output logic         auth_busy,
  output logic [127:0] card_id,
  output logic         card_id_valid,
  output logic         aes_start,
  output logic         aes_mode,
  output logic [127:0] aes_key,
  output logic [127:0] aes_block_in,
  input  logic [127:0] aes_block_out,
  input  logic         aes_done,
  output logic         nonce_req,
  input  logic         nonce_valid,
  input  logic [63:0]  nonce,
  output logic         nfc_cmd_valid,
  input  logic         nfc_cmd_ready,
  output logic         nfc_cmd_write,
  output logic [5:0]   nfc_cmd_addr,
  output logic [7:0]   nfc_cmd_wdata,
  input  logic [7:0]   nfc_cmd_rdata,
  input  logic         nfc_cmd_done,
  output logic         timeout_start,
  input  logic         timeout_occurred
);

  typedef enum logic [4:0] {
    IDLE, KEY_REQ, KEY_WAIT, NONCE_REQ, NONCE_WAIT, TX_RN, TX_RN_WAIT,
    RX_RESP, RX_RESP_WAIT, DEC_START, DEC_WAIT, VERIFY, ENC_START, ENC_WAIT,
    TX_ACK, TX_ACK_WAIT, SUCCESS, FAIL
  } state_t;

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic [63:0]    rn_q;
  logic [127:0]   resp_q;
  logic [127:0]   p_q;
  logic           acc_q;

  logic           nfc_acc;
  logic           nfc_cpl;
  logic           to_win;
  logic [6:0]     sh16;
  logic [5:0]     sh8;

  // A command may complete in its acceptance cycle or any later cycle.
  assign nfc_acc = nfc_cmd_valid && nfc_cmd_ready;
  assign nfc_cpl = nfc_cmd_done && (acc_q || nfc_acc);
  assign to_win  = (state_q >= TX_RN) && (state_q <= TX_ACK_WAIT);
  // Byte i of a big-endian word lives at bit offset 8*(N-1-i).
  assign sh16    = {~cnt_q, 3'b000};
  assign sh8     = {~cnt_q[2:0], 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rn_q          <= '0;
      resp_q        <= '0;
      p_q           <= '0;
      acc_q         <= 1'b0;
      key_load_req  <= 1'b0;
      key_addr      <= '0;
      auth_success  <= 1'b0;
      auth_failed   <= 1'b0;
      auth_busy     <= 1'b0;
      card_id       <= '0;
      card_id_valid <= 1'b0;
      aes_start     <= 1'b0;
      aes_mode      <= 1'b0;
      aes_key       <= '0;
      aes_block_in  <= '0;
      nonce_req     <= 1'b0;
      nfc_cmd_valid <= 1'b0;
      nfc_cmd_write <= 1'b0;
      nfc_cmd_addr  <= '0;
      nfc_cmd_wdata <= '0;
      timeout_start <= 1'b0;
    end else begin
      key_load_req  <= 1'b0;
      nonce_req     <= 1'b0;
      aes_start     <= 1'b0;
      timeout_start <= 1'b0;
      if (to_win && timeout_occurred) begin
        state_q       <= FAIL;
        auth_failed   <= 1'b1;
        auth_busy     <= 1'b0;
        card_id_valid <= 1'b0;
        nfc_cmd_valid <= 1'b0;
        acc_q         <= 1'b0;
      end else begin
        case (state_q)
          IDLE, SUCCESS, FAIL: begin
            if (start_auth) begin
              auth_success  <= 1'b0;
              auth_failed   <= 1'b0;
              card_id_valid <= 1'b0;
              cnt_q         <= '0;
              auth_busy     <= 1'b1;
              state_q       <= KEY_REQ;
            end
          end
          KEY_REQ: begin
            key_load_req <= 1'b1;
            key_addr     <= KEY_BASE_ADDR + {3'b000, cnt_q};
            state_q      <= KEY_WAIT;
          end
          KEY_WAIT: begin
            if (key_data_valid) begin
              aes_key[sh16 +: 8] <= key_data;
              cnt_q              <= cnt_q + 4'd1;
              state_q            <= (cnt_q == 4'd15) ? NONCE_REQ : KEY_REQ;
            end
          end
          NONCE_REQ: begin
            nonce_req <= 1'b1;
            state_q   <= NONCE_WAIT;
          end
          NONCE_WAIT: begin
            if (nonce_valid) begin
              rn_q    <= nonce;
              cnt_q   <= '0;
              state_q <= TX_RN;
            end
          end
          TX_RN: begin
            nfc_cmd_valid <= 1'b1;
            nfc_cmd_write <= 1'b1;
            nfc_cmd_addr  <= NFC_CHAL_ADDR + {2'b00, cnt_q};
            nfc_cmd_wdata <= rn_q[sh8 +: 8];
            state_q       <= TX_RN_WAIT;
          end
          RX_RESP: begin
            nfc_cmd_valid <= 1'b1;
            nfc_cmd_write <= 1'b0;
            nfc_cmd_addr  <= NFC_RESP_ADDR + {2'b00, cnt_q};
            state_q       <= RX_RESP_WAIT;
          end
          TX_ACK: begin
            nfc_cmd_valid <= 1'b1;
            nfc_cmd_write <= 1'b1;
            nfc_cmd_addr  <= NFC_ACK_ADDR + {2'b00, cnt_q};
            nfc_cmd_wdata <= resp_q[sh16 +: 8];
            state_q       <= TX_ACK_WAIT;
          end
          TX_RN_WAIT, RX_RESP_WAIT, TX_ACK_WAIT: begin
            if (nfc_cpl) begin
              nfc_cmd_valid <= 1'b0;
              acc_q         <= 1'b0;
              cnt_q         <= cnt_q + 4'd1;
              if (state_q == TX_RN_WAIT) begin
                if (cnt_q == 4'd7) begin
                  cnt_q         <= '0;
                  timeout_start <= 1'b1;
                  state_q       <= RX_RESP;
                end else begin
                  state_q <= TX_RN;
                end
              end else if (state_q == RX_RESP_WAIT) begin
                resp_q[sh16 +: 8] <= nfc_cmd_rdata;
                state_q           <= (cnt_q == 4'd15) ? DEC_START : RX_RESP;
              end else if (cnt_q == 4'd15) begin
                auth_success  <= 1'b1;
                card_id_valid <= 1'b1;
                auth_busy     <= 1'b0;
                state_q       <= SUCCESS;
              end else begin
                state_q <= TX_ACK;
              end
            end else if (nfc_acc) begin
              nfc_cmd_valid <= 1'b0;
              acc_q         <= 1'b1;
            end
          end
          DEC_START: begin
            aes_start    <= 1'b1;
            aes_mode     <= 1'b0;
            aes_block_in <= resp_q;
            state_q      <= DEC_WAIT;
          end
          DEC_WAIT: begin
            if (aes_done) begin
              p_q     <= aes_block_out;
              state_q <= VERIFY;
            end
          end
          VERIFY: begin
            if (p_q[127:64] == rn_q) begin
              card_id <= p_q;
`ifdef MUTUAL_AUTH_EN
              state_q <= ENC_START;
`else
              auth_success  <= 1'b1;
              card_id_valid <= 1'b1;
              auth_busy     <= 1'b0;
              state_q       <= SUCCESS;
`endif
            end else begin
              auth_failed   <= 1'b1;
              auth_busy     <= 1'b0;
              card_id_valid <= 1'b0;
              state_q       <= FAIL;
            end
          end
          ENC_START: begin
            aes_start    <= 1'b1;
            aes_mode     <= 1'b1;
            aes_block_in <= {p_q[63:0], rn_q};
            state_q      <= ENC_WAIT;
          end
          ENC_WAIT: begin
            // The proof reuses the response buffer; the response is no longer needed.
            if (aes_done) begin
              resp_q  <= aes_block_out;
              cnt_q   <= '0;
              state_q <= TX_ACK;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_auth_controller.sv
// Randomized bench for auth_controller: EEPROM/RNG/NFC-card/XOR-AES mocks and an outcome model.
module tb_auth_controller;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_auth = 1'b0;
  logic         key_load_req;
  logic [6:0]   key_addr;
  logic [7:0]   key_data;
  logic         key_data_valid;
  logic         auth_success, auth_failed, auth_busy;
  logic [127:0] card_id;
  logic         card_id_valid;
  logic         aes_start, aes_mode;
  logic [127:0] aes_key, aes_block_in, aes_block_out;
  logic         aes_done;
  logic         nonce_req, nonce_valid;
  logic [63:0]  nonce;
  logic         nfc_cmd_valid, nfc_cmd_ready, nfc_cmd_write;
  logic [5:0]   nfc_cmd_addr;
  logic [7:0]   nfc_cmd_wdata, nfc_cmd_rdata;
  logic         nfc_cmd_done;
  logic         timeout_start, timeout_occurred;

  always #5 clk = ~clk;

  auth_controller dut (
    .clk(clk), .rst_n(rst_n), .start_auth(start_auth),
    .key_load_req(key_load_req), .key_addr(key_addr), .key_data(key_data),
    .key_data_valid(key_data_valid), .auth_success(auth_success), .auth_failed(auth_failed),
    .auth_busy(auth_busy), .card_id(card_id), .card_id_valid(card_id_valid),
    .aes_start(aes_start), .aes_mode(aes_mode), .aes_key(aes_key),
    .aes_block_in(aes_block_in), .aes_block_out(aes_block_out), .aes_done(aes_done),
    .nonce_req(nonce_req), .nonce_valid(nonce_valid), .nonce(nonce),
    .nfc_cmd_valid(nfc_cmd_valid), .nfc_cmd_ready(nfc_cmd_ready), .nfc_cmd_write(nfc_cmd_write),
    .nfc_cmd_addr(nfc_cmd_addr), .nfc_cmd_wdata(nfc_cmd_wdata), .nfc_cmd_rdata(nfc_cmd_rdata),
    .nfc_cmd_done(nfc_cmd_done), .timeout_start(timeout_start), .timeout_occurred(timeout_occurred)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scenario configuration and observation logs shared with the mock process.
  logic [127:0] cfg_psk, cfg_resp;
  logic [63:0]  cfg_rn;
  bit           cfg_rnd;
  int           cfg_to;
  bit           mock_rst;
  bit           to_fired;
  logic [6:0]   key_log[$];
  logic [5:0]   chal_a[$], rd_a[$], ack_a[$];
  logic [7:0]   chal_d[$], ack_d[$];
  int           ts_cnt, nr_cnt, both_hi;
  logic [127:0] key_at_nonce;

  initial begin
    bit kp, np, fb, ab;
    int kdly, ndly, fdly, adly, k;
    logic [6:0] ka;
    logic [7:0] frd;
    logic [127:0] aout, t;
    kp = 0; np = 0; fb = 0; ab = 0; kdly = 0; ndly = 0; fdly = 0; adly = 0;
    ka = '0; frd = '0; aout = '0;
    key_data = '0; key_data_valid = 0; nonce = '0; nonce_valid = 0;
    nfc_cmd_ready = 0; nfc_cmd_done = 0; nfc_cmd_rdata = '0;
    aes_block_out = '0; aes_done = 0; timeout_occurred = 0;
    forever begin
      @(negedge clk);
      key_data_valid = 0; nonce_valid = 0; nfc_cmd_ready = 0; nfc_cmd_done = 0;
      aes_done = 0; timeout_occurred = 0;
      if (to_fired) begin
        chk("timeout_fail_1cyc", {126'b0, auth_failed, auth_busy}, 128'b10);
        to_fired = 0;
      end
      if (mock_rst) begin
        kp = 0; np = 0; fb = 0; ab = 0;
      end else begin
        if (auth_success && auth_failed) both_hi++;
        if (timeout_start) ts_cnt++;
        if (key_load_req) begin
          key_log.push_back(key_addr);
          kp = 1; ka = key_addr; kdly = cfg_rnd ? $urandom_range(0, 2) : 1;
        end
        if (kp) begin
          if (kdly == 0) begin
            k = int'(ka);
            t = cfg_psk >> (8 * (15 - k));
            key_data = t[7:0]; key_data_valid = 1; kp = 0;
          end else kdly--;
        end
        if (nonce_req) begin
          nr_cnt++; key_at_nonce = aes_key;
          np = 1; ndly = cfg_rnd ? $urandom_range(0, 3) : 1;
        end
        if (np) begin
          if (ndly == 0) begin nonce = cfg_rn; nonce_valid = 1; np = 0; end
          else ndly--;
        end
        if (!fb && nfc_cmd_valid && (!cfg_rnd || ($urandom % 2 == 0))) begin
          nfc_cmd_ready = 1; fb = 1;
          fdly = cfg_rnd ? $urandom_range(0, 2) : 0;
          if (nfc_cmd_write) begin
            if (nfc_cmd_addr < 6'h10) begin chal_a.push_back(nfc_cmd_addr); chal_d.push_back(nfc_cmd_wdata); end
            else begin ack_a.push_back(nfc_cmd_addr); ack_d.push_back(nfc_cmd_wdata); end
          end else begin
            rd_a.push_back(nfc_cmd_addr);
            k = int'(nfc_cmd_addr) - 16;
            t = cfg_resp >> (8 * (15 - k));
            frd = t[7:0];
            if (k == cfg_to) begin timeout_occurred = 1; to_fired = 1; end
          end
        end
        if (fb) begin
          if (fdly == 0) begin nfc_cmd_done = 1; nfc_cmd_rdata = frd; fb = 0; end
          else fdly--;
        end
        if (aes_start) begin
          ab = 1; aout = aes_block_in ^ aes_key;
          adly = cfg_rnd ? $urandom_range(0, 3) : 0;
        end
        if (ab) begin
          if (adly == 0) begin aes_block_out = aout; aes_done = 1; ab = 0; end
          else adly--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_ctl"}, {110'b0, key_load_req, key_addr, auth_success, auth_failed, auth_busy,
        card_id_valid, aes_start, aes_mode, nonce_req, nfc_cmd_valid, nfc_cmd_write, timeout_start}, 128'b0);
    chk({tag, "_nfc"}, {114'b0, nfc_cmd_addr, nfc_cmd_wdata}, 128'b0);
    chk({tag, "_key"}, aes_key, 128'b0);
    chk({tag, "_blk"}, aes_block_in, 128'b0);
    chk({tag, "_cid"}, card_id, 128'b0);
    chk({tag, "_state"}, {123'b0, dut.state_q}, 128'b0);
  endtask

  // mode: 0 genuine card, 1 constant 8'hAA bytes, 2 genuine response with one challenge bit flipped.
  task automatic run(input string tag, input logic [127:0] p, input logic [63:0] rn,
                     input logic [63:0] idlo, input int mode, input bit rnd, input int to_b, input bit poke);
    logic [127:0] resp, pt, ack, t;
    logic [63:0]  r;
    bit ok;
    int cyc;
    resp = {rn, idlo} ^ p;
    if (mode == 1) resp = {16{8'hAA}};
    if (mode == 2) resp = resp ^ (128'h1 << (64 + $urandom_range(0, 63)));
    cfg_psk = p; cfg_rn = rn; cfg_resp = resp; cfg_rnd = rnd; cfg_to = to_b;
    mock_rst = 1; tick(); tick(); mock_rst = 0;
    key_log.delete(); chal_a.delete(); chal_d.delete(); rd_a.delete(); ack_a.delete(); ack_d.delete();
    ts_cnt = 0; nr_cnt = 0; both_hi = 0; key_at_nonce = '0;
    start_auth = 1; tick(); start_auth = 0;
    chk({tag, "_start"}, {124'b0, auth_busy, auth_success, auth_failed, card_id_valid}, 128'b1000);
    if (poke) begin
      repeat (10) tick();
      start_auth = 1; tick(); start_auth = 0;
    end
    cyc = 0;
    while (auth_busy && cyc < 3000) begin tick(); cyc++; end
    chk({tag, "_finish_in_time"}, 128'(cyc < 3000), 128'b1);
    pt = resp ^ p;
    ok = (to_b < 0) && (pt[127:64] == rn);
    chk({tag, "_key_reqs"}, 128'(key_log.size()), 128'd16);
    foreach (key_log[i]) chk({tag, "_key_addr"}, 128'(key_log[i]), 128'(i));
    chk({tag, "_key_at_nonce"}, key_at_nonce, p);
    chk({tag, "_nonce_reqs"}, 128'(nr_cnt), 128'd1);
    chk({tag, "_chal_cnt"}, 128'(chal_a.size()), 128'd8);
    foreach (chal_a[i]) begin
      r = rn << (8 * i);
      chk({tag, "_chal"}, {chal_a[i], chal_d[i]}, {6'(i), r[63:56]});
    end
    chk({tag, "_timer_arms"}, 128'(ts_cnt), 128'd1);
    if (to_b < 0) begin
      chk({tag, "_resp_reads"}, 128'(rd_a.size()), 128'd16);
      foreach (rd_a[i]) chk({tag, "_resp_addr"}, 128'(rd_a[i]), 128'(16 + i));
    end
    chk({tag, "_result"}, {124'b0, auth_success, auth_failed, card_id_valid, auth_busy},
        {124'b0, ok, !ok, ok, 1'b0});
    chk({tag, "_never_both"}, 128'(both_hi), 128'd0);
    if (ok) chk({tag, "_card_id"}, card_id, pt);
`ifdef MUTUAL_AUTH_EN
    chk({tag, "_ack_cnt"}, 128'(ack_a.size()), ok ? 128'd16 : 128'd0);
    ack = {pt[63:0], rn} ^ p;
    foreach (ack_a[i]) begin
      t = ack << (8 * i);
      chk({tag, "_ack"}, {ack_a[i], ack_d[i]}, {6'(32 + i), t[127:120]});
    end
`else
    ack = '0;
    t = ack;
    chk({tag, "_ack_cnt"}, 128'(ack_a.size()), 128'(t[0]));
`endif
  endtask

  localparam logic [127:0] PSK = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    int c;
    cfg_psk = PSK; cfg_rn = '0; cfg_resp = '0; cfg_rnd = 0; cfg_to = -1;
    mock_rst = 1; to_fired = 0; ts_cnt = 0; nr_cnt = 0; both_hi = 0; key_at_nonce = '0;
    #1;
    rst_check("por");
    #20; rst_n = 1; tick();

    run("plan_ok", PSK, 64'hfedcba9876543210, 64'h0123456789abcdef, 0, 0, -1, 0);
    chk("plan_card_id", card_id, 128'hfedcba98765432100123456789abcdef);
    run("plan_aa", PSK, 64'hfedcba9876543210, 64'h0123456789abcdef, 1, 0, -1, 0);
    chk("plan_aa_flags", {125'b0, auth_success, auth_failed, card_id_valid}, 128'b010);
    run("plan_tmo", PSK, 64'hfedcba9876543210, 64'h0123456789abcdef, 0, 0, 5, 0);
    run("plan_restart", PSK, 64'h0f1e2d3c4b5a6978, 64'h1122334455667788, 0, 0, -1, 1);

    // Reset asserted while the controller waits on EEPROM data.
    mock_rst = 1; tick(); mock_rst = 0;
    start_auth = 1; tick(); start_auth = 0;
    c = 0;
    while (!key_load_req && c < 50) begin tick(); c++; end
    chk("kw_reached", 128'(key_load_req), 128'b1);
    repeat (3) tick();
    while (!key_load_req && c < 100) begin tick(); c++; end
    rst_n = 0; #1;
    rst_check("kw_rst");
    tick(); rst_n = 1; tick();
    run("post_rst", PSK, 64'hfedcba9876543210, 64'h0123456789abcdef, 0, 1, -1, 0);

    for (int i = 0; i < 12; i++) begin
      logic [127:0] p;
      logic [63:0] rn, id;
      int mode, tb;
      p = {$urandom, $urandom, $urandom, $urandom};
      rn = {$urandom, $urandom};
      id = {$urandom, $urandom};
      mode = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 2);
      tb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1;
      run($sformatf("rnd%0d", i), p, rn, id, mode, 1, tb, ($urandom % 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
